// File: rtl/logic_bist_ctrl_pkg.sv
// logic_bist_ctrl_pkg: shared state encodings, defaults and golden tables for the BIST sequencer
package logic_bist_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int N_IN_DEF   = 3;
   localparam int SETTLE_DEF = 2;

   // existing 3-input network: output low only when A=B=C=1
   localparam logic [7:0] GOLDEN_NAND_MIX = 8'h7F;

endpackage

// File: rtl/logic_bist_ctrl_settle_timer.sv
// bist_settle_timer: loadable down-counter whose expiry marks the end of the settle interval
module bist_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_expire
);

   logic [W-1:0] r_cnt;

   assign o_expire = i_en && (r_cnt == '0);

   // reload on request, otherwise count down to zero while enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

endmodule

// File: rtl/logic_bist_ctrl.sv
// logic_bist_ctrl: walks every input vector through a gate network and checks it against a truth table
module logic_bist_ctrl
   import logic_bist_ctrl_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   golden,
   input  logic                 dut_out,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic                 fail_valid,
   output logic [N_IN-1:0]      fail_vec
);

   state_t              r_state, w_state_nxt;
   logic [2**N_IN-1:0]  r_golden;
   logic [N_IN-1:0]     r_vec, r_fail_vec;
   logic [N_IN:0]       r_err, w_err_nxt;
   logic                r_busy, r_done, r_pass, r_fail_valid;
   logic                w_accept, w_check, w_last, w_mismatch, w_expire;

   assign w_accept   = start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_check    = (r_state == ST_CHECK);
   assign w_last     = (r_vec == '1);
   assign w_mismatch = w_check && (dut_out != r_golden[r_vec]);
   assign w_err_nxt  = r_err + {{N_IN{1'b0}}, w_mismatch};

   // settle countdown restarts whenever a new vector is put on the network
   bist_settle_timer #(.W(4)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept || (w_check && !w_last)),
      .i_load_val (4'(SETTLE - 1)),
      .i_en       (r_state == ST_WAIT),
      .o_expire   (w_expire)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  w_state_nxt = start ? ST_WAIT : ST_IDLE;
         ST_WAIT:  w_state_nxt = w_expire ? ST_CHECK : ST_WAIT;
         ST_CHECK: w_state_nxt = w_last ? ST_DONE : ST_WAIT;
         ST_DONE:  w_state_nxt = start ? ST_WAIT : ST_DONE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // vector, golden latch and result bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_golden     <= '0;
         r_vec        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else if (w_accept) begin
         r_golden     <= golden;
         r_vec        <= '0;
         r_busy       <= 1'b1;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else if (w_check) begin
         r_err <= w_err_nxt;
         if (w_mismatch && !r_fail_valid) begin
            r_fail_vec   <= r_vec;
            r_fail_valid <= 1'b1;
         end
         if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_err_nxt == '0);
         end else
            r_vec <= r_vec + 1'b1;
      end
   end

   assign vec_out    = r_vec;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_cnt    = r_err;
   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_logic_bist_ctrl.sv
// tb_logic_bist_ctrl: directed runs of the BIST sequencer against a behavioural gate network
module tb_logic_bist_ctrl;
   import logic_bist_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] golden = 8'h00;
   logic       dut_out;
   logic [2:0] vec_out;
   logic       busy, done, pass, fail_valid;
   logic [3:0] err_cnt;
   logic [2:0] fail_vec;

   int checks = 0;
   int failures = 0;
   int mode = 0;
   int q[$];

   logic_bist_ctrl #(.N_IN(3), .SETTLE(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .golden     (golden),
      .dut_out    (dut_out),
      .vec_out    (vec_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_cnt    (err_cnt),
      .fail_valid (fail_valid),
      .fail_vec   (fail_vec)
   );

   // network model: 0 correct NAND, 1 stuck-at-1, 2 inverted
   assign dut_out = (mode == 1) ? 1'b1 : (mode == 2) ? (&vec_out) : ~(&vec_out);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vec"}, 32'(vec_out), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"}, 32'(err_cnt), 0);
      chk({tag, "_fvalid"}, 32'(fail_valid), 0);
      chk({tag, "_fvec"}, 32'(fail_vec), 0);
   endtask

   // one full run; golden is scrambled after start to prove it was latched
   task automatic run(input string tag, input logic [7:0] g, input int m, input int pulse_edge,
                      input int exp_err, input int exp_fv, input logic exp_fvalid, input logic exp_pass);
      mode = m;
      golden = g;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      golden = ~g;
      for (int i = 0; i < 8; i++) q.push_back(i);
      chk({tag, "_vec0"}, 32'(vec_out), 32'(q.pop_front()));
      chk({tag, "_busy0"}, 32'(busy), 1);
      chk({tag, "_done0"}, 32'(done), 0);
      chk({tag, "_err0"}, 32'(err_cnt), 0);
      chk({tag, "_fvalid0"}, 32'(fail_valid), 0);
      for (int e = 1; e <= 24; e++) begin
         @(posedge clk); #1;
         start = (e == pulse_edge);
         if (e % 3 == 0 && e < 24 && q.size() > 0)
            chk($sformatf("%s_vec_e%0d", tag, e), 32'(vec_out), 32'(q.pop_front()));
         if (e == 23)
            chk({tag, "_done_early"}, 32'(done), 0);
      end
      start = 1'b0;
      chk({tag, "_q_empty"}, 32'(q.size()), 0);
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_vec_end"}, 32'(vec_out), 7);
      chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
      chk({tag, "_fvec"}, 32'(fail_vec), 32'(exp_fv));
      chk({tag, "_fvalid"}, 32'(fail_valid), 32'(exp_fvalid));
      chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 0);

      run("good", GOLDEN_NAND_MIX, 0, -1, 0, 0, 1'b0, 1'b1);
      run("restart_ff", 8'hFF, 0, -1, 1, 7, 1'b1, 1'b0);
      run("stuck1", GOLDEN_NAND_MIX, 1, -1, 1, 7, 1'b1, 1'b0);
      run("invert", GOLDEN_NAND_MIX, 2, -1, 8, 0, 1'b1, 1'b0);
      run("pulse", GOLDEN_NAND_MIX, 0, 9, 0, 0, 1'b0, 1'b1);

      mode = 0;
      golden = GOLDEN_NAND_MIX;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("midrun_vec5", 32'(vec_out), 5);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk_reset_vals("post_rst_idle");

      run("recover", GOLDEN_NAND_MIX, 0, -1, 0, 0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
